// File: rtl/dff_share_arb_pkg.sv
// Shared definitions for the dff_share_arb block: the sequencer state
// encoding, the index-width helper and a one-hot encoder.
package dff_share_arb_pkg;

    // Largest supported requester count; bounds the one-hot helper width.
    localparam int MAX_N = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Width of a requester index, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One-hot vector with bit idx set; all zero when idx is out of range.
    function automatic logic [MAX_N-1:0] onehot(input int idx, input int n);
        logic [MAX_N-1:0] v;
        v = '0;
        if (idx >= 0 && idx < n && idx < MAX_N) begin
            v = MAX_N'(1) << idx;
        end
        return v;
    endfunction

endpackage

// File: rtl/dff.sv
// Dff: WIDTH-bit storage register with synchronous active-low reset.
// Ports: clk, reset (active-low, synchronous), d (next value), q (stored value).
module dff #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/dff_share_arb_rr_pick.sv
// rr_pick: combinational rotate-priority picker. Scans req starting at
// rr_ptr and wrapping N-1 -> 0; the first set bit wins.
// Ports: req (requests), rr_ptr (scan start), valid (any request),
//        winner (index of the winning requester).
module rr_pick
    import dff_share_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [idx_w(N)-1:0]   rr_ptr,
    output logic                  valid,
    output logic [idx_w(N)-1:0]   winner
);

    localparam int IW = idx_w(N);

    int            j;
    logic [IW-1:0] idx;

    // NOTE: every output and temporary gets a default first so no latch is inferred.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        j      = 0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            idx = IW'(j);
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/dff_share_arb.sv
// dff_share_arb: round-robin arbiter/sequencer sharing one WIDTH-bit Dff
// among N requesters. A granted requester holding lock keeps the register
// for a multi-cycle burst.
// Optional feature: define DFF_SHARE_ARB_TIMEOUT_EN to bound locks to
// MAX_LOCK locked cycles; a forced release pulses timeout_err and masks the
// owner's lock until it drops lock for a cycle.
// Ports: clk, reset (sync active-low), req/lock (per requester),
//        wdata (slice i = wdata[i*WIDTH +: WIDTH]), gnt (registered one-hot),
//        q (register value), owner (last granted index), busy (LOCKED),
//        timeout_err (forced-release pulse).
module dff_share_arb
    import dff_share_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_LOCK = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0]          req,
    input  logic [N-1:0]          lock,
    input  logic [N*WIDTH-1:0]    wdata,
    output logic [N-1:0]          gnt,
    output logic [WIDTH-1:0]      q,
    output logic [idx_w(N)-1:0]   owner,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int IW = idx_w(N);

    state_t          state, state_n;
    logic [IW-1:0]   rr_ptr, rr_n, owner_n;
    logic [N-1:0]    gnt_n, lock_eff;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] slice [N];
    logic            pick_valid;
    logic [IW-1:0]   pick_w;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        int v;
        v = int'(i) + 1;
        if (v >= N) begin
            v = 0;
        end
        return IW'(v);
    endfunction

    function automatic logic [N-1:0] sel_onehot(input logic [IW-1:0] i);
        logic [MAX_N-1:0] v;
        v = onehot(int'(i), N);
        return v[N-1:0];
    endfunction

    for (genvar i = 0; i < N; i++) begin : g_slice
        assign slice[i] = wdata[i*WIDTH +: WIDTH];
    end

    rr_pick #(.N(N)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid),
        .winner (pick_w)
    );

    dff #(.WIDTH(WIDTH)) u_dff (
        .clk   (clk),
        .reset (reset),
        .d     (d),
        .q     (q)
    );

    assign busy = (state == LOCKED);

`ifdef DFF_SHARE_ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_LOCK + 1);
    logic [CW-1:0] lock_cnt, lock_cnt_n;
    logic [N-1:0]  lock_mask, lock_mask_n;
    logic          terr_n;

    // A timed-out owner's lock is ignored until it drops lock once.
    assign lock_eff = lock & ~lock_mask;
`else
    logic unused_max_lock;
    assign unused_max_lock = (MAX_LOCK != 0);
    assign lock_eff        = lock;
    assign timeout_err     = 1'b0;
`endif

    always_comb begin
        state_n = state;
        gnt_n   = '0;
        owner_n = owner;
        rr_n    = rr_ptr;
        d       = q;  // no write: feed q back so the register holds
`ifdef DFF_SHARE_ARB_TIMEOUT_EN
        lock_cnt_n  = lock_cnt;
        lock_mask_n = lock_mask & lock;
        terr_n      = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    d       = slice[pick_w];
                    gnt_n   = sel_onehot(pick_w);
                    owner_n = pick_w;
                    rr_n    = next_idx(pick_w);
                    if (lock_eff[pick_w]) begin
                        state_n = LOCKED;
`ifdef DFF_SHARE_ARB_TIMEOUT_EN
                        lock_cnt_n = '0;
`endif
                    end
                end
            end
            LOCKED: begin
                if (!req[owner] || !lock_eff[owner]) begin
                    // Voluntary release; a final write may ride along.
                    if (req[owner]) begin
                        d     = slice[owner];
                        gnt_n = sel_onehot(owner);
                    end
                    state_n = IDLE;
                    rr_n    = next_idx(owner);
`ifdef DFF_SHARE_ARB_TIMEOUT_EN
                end else if (lock_cnt == CW'(MAX_LOCK - 1)) begin
                    // Forced release after MAX_LOCK locked cycles, no write.
                    state_n             = IDLE;
                    rr_n                = next_idx(owner);
                    terr_n              = 1'b1;
                    lock_mask_n[owner]  = 1'b1;
`endif
                end else begin
                    d     = slice[owner];
                    gnt_n = sel_onehot(owner);
`ifdef DFF_SHARE_ARB_TIMEOUT_EN
                    lock_cnt_n = lock_cnt + CW'(1);
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            gnt    <= '0;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_n;
            gnt    <= gnt_n;
            owner  <= owner_n;
            rr_ptr <= rr_n;
        end
    end

`ifdef DFF_SHARE_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            lock_cnt    <= '0;
            lock_mask   <= '0;
            timeout_err <= 1'b0;
        end else begin
            lock_cnt    <= lock_cnt_n;
            lock_mask   <= lock_mask_n;
            timeout_err <= terr_n;
        end
    end
`endif

endmodule

// File: tb/tb_dff_share_arb.sv
// Self-checking bench for dff_share_arb (N=4, WIDTH=8, MAX_LOCK=4):
// directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a behavioural model.
module tb_dff_share_arb;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int ML = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req, lock;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [W-1:0]   q;
    logic [1:0]     owner;
    logic           busy, timeout_err;

    int vectors     = 0;
    int miscompares = 0;

    dff_share_arb #(.N(N), .WIDTH(W), .MAX_LOCK(ML)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .lock        (lock),
        .wdata       (wdata),
        .gnt         (gnt),
        .q           (q),
        .owner       (owner),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         m_valid = 1'b0;
    logic [7:0] m_q;
    logic [3:0] m_gnt, m_mask;
    int         m_owner, m_rr, m_age;
    bit         m_locked, m_terr;

    always @(posedge clk) begin
        int         w;
        int         o;
        logic [3:0] eff, new_mask;
        if (!reset) begin
            m_q = 0; m_gnt = 0; m_owner = 0; m_rr = 0; m_locked = 0;
            m_age = 0; m_mask = 0; m_terr = 0; m_valid = 1'b1;
        end else if (m_valid) begin
`ifdef DFF_SHARE_ARB_TIMEOUT_EN
            eff = lock & ~m_mask;
`else
            eff = lock;
`endif
            new_mask = m_mask & lock;
            m_gnt  = 0;
            m_terr = 0;
            if (!m_locked) begin
                w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && req[(m_rr + k) % N]) w = (m_rr + k) % N;
                if (w >= 0) begin
                    m_q     = wdata[w*W +: W];
                    m_gnt   = 4'(1 << w);
                    m_owner = w;
                    m_rr    = (w + 1) % N;
                    if (eff[w]) begin m_locked = 1; m_age = 0; end
                end
            end else begin
                o = m_owner;
                if (!req[o] || !eff[o]) begin
                    if (req[o]) begin m_q = wdata[o*W +: W]; m_gnt = 4'(1 << o); end
                    m_locked = 0;
                    m_rr     = (o + 1) % N;
`ifdef DFF_SHARE_ARB_TIMEOUT_EN
                end else if (m_age + 1 >= ML) begin
                    m_locked    = 0;
                    m_rr        = (o + 1) % N;
                    m_terr      = 1;
                    new_mask[o] = 1'b1;
`endif
                end else begin
                    m_q   = wdata[o*W +: W];
                    m_gnt = 4'(1 << o);
                    m_age = m_age + 1;
                end
            end
            m_mask = new_mask;
        end
    end

    // Single compare process: outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_gnt",   32'(gnt),         32'(m_gnt));
            check("model_q",     32'(q),           32'(m_q));
            check("model_owner", 32'(owner),       32'(m_owner));
            check("model_busy",  32'(busy),        32'(m_locked));
            check("model_terr",  32'(timeout_err), 32'(m_terr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [7:0] base);
        for (int i = 0; i < N; i++) wdata[i*W +: W] = base + 8'(i);
    endtask

    initial begin
        logic [3:0] g3 [5];
        logic [7:0] q3 [5];
        logic [3:0] g6 [10];
        logic       b6 [10];
        logic       t6 [10];
        g3 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        q3 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        g6 = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
               4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
        b6 = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        t6 = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};

        // 1. reset with all requests high
        reset = 1'b0; req = 4'b1111; lock = 4'b0000; set_data(8'h10);
        step(); step();
        check("s1_q", 32'(q), 32'h00);
        check("s1_gnt", 32'(gnt), 32'h0);
        check("s1_busy", 32'(busy), 32'h0);
        check("s1_owner", 32'(owner), 32'h0);
        reset = 1'b1;
        step();
        check("s1_first_gnt", 32'(gnt), 32'b0001);

        // 2. single write then hold
        reset = 1'b0; step(); reset = 1'b1;
        req = 4'b0010; wdata = '0; wdata[1*W +: W] = 8'hA5;
        step();
        check("s2_gnt", 32'(gnt), 32'b0010);
        check("s2_q", 32'(q), 32'hA5);
        check("s2_owner", 32'(owner), 32'h1);
        req = 4'b0000;
        step();
        check("s2_hold_q", 32'(q), 32'hA5);
        check("s2_hold_gnt", 32'(gnt), 32'h0);

        // 3. round-robin fairness
        reset = 1'b0; step(); reset = 1'b1;
        set_data(8'h10); req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            check("s3_gnt", 32'(gnt), 32'(g3[i]));
            check("s3_q", 32'(q), 32'(q3[i]));
        end

        // 4. lock burst starting from rr_ptr=2
        reset = 1'b0; step(); reset = 1'b1;
        req = 4'b0010; step();
        req = 4'b1111; lock = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            step();
            check("s4_lock_gnt", 32'(gnt), 32'b0100);
            check("s4_lock_busy", 32'(busy), 32'h1);
        end
        lock = 4'b0000;
        step();
        check("s4_rel_gnt", 32'(gnt), 32'b0100);
        check("s4_rel_busy", 32'(busy), 32'h0);
        step();
        check("s4_next_gnt", 32'(gnt), 32'b1000);

        // 5. reset in the middle of a lock
        reset = 1'b0; step(); reset = 1'b1;
        req = 4'b1111; lock = 4'b0001;
        step();
        check("s5_busy_pre", 32'(busy), 32'h1);
        reset = 1'b0;
        step();
        check("s5_busy", 32'(busy), 32'h0);
        check("s5_gnt", 32'(gnt), 32'h0);
        check("s5_q", 32'(q), 32'h00);
        reset = 1'b1; lock = 4'b0000;
        step();
        check("s5_first_gnt", 32'(gnt), 32'b0001);

`ifdef DFF_SHARE_ARB_TIMEOUT_EN
        // 6. lock timeout with MAX_LOCK=4
        reset = 1'b0; step(); reset = 1'b1;
        set_data(8'h20); req = 4'b0011; lock = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            step();
            check("s6_gnt", 32'(gnt), 32'(g6[i]));
            check("s6_busy", 32'(busy), 32'(b6[i]));
            check("s6_terr", 32'(timeout_err), 32'(t6[i]));
        end
        lock = 4'b0000;
`endif

        // randomized traffic checked by the model
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 1) == 0) req = 4'($urandom);
            if ($urandom_range(0, 1) == 0)
                lock = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'($urandom_range(0, 1));
            wdata = N*W'($urandom);
            step();
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dff_share_arb.md
Name: dff_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one WIDTH-bit Dff storage register among N requesters.
- Each cycle it selects one write source and drives the Dff input.
- Feeds back q to hold the value when no write occurs.
- Supports a lock so that one requester can own the register for multi-cycle bursts.

Parameters:
- N, 4: number of requesters (2..16).
- WIDTH, 8: data width of the shared register.
- MAX_LOCK, 16: lock timeout in cycles; used only with DFF_SHARE_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- req  input  N  per-requester write request.
- lock  input  N  per-requester lock request, qualified by req.
- wdata  input  N*WIDTH  write data; slice i = wdata[i*WIDTH +: WIDTH].
- gnt  output  N  registered one-hot grant; high in cycle t+1 means the requester's cycle-t write was taken.
- q  output  WIDTH  current shared register value (Dff output).
- owner  output  $clog2(N)  index of the last granted requester.
- busy  output  1  high while in LOCKED.
- timeout_err  output  1  one-cycle pulse on forced lock release; tied 0 without the macro.

Behaviour:
- One clock, clk. Reset is synchronous and active-low: reset low at a rising edge clears all state.
- Reset values: q=0, gnt=0, owner=0, busy=0, timeout_err=0, rr_ptr=0, state=IDLE, lock counter=0.
- A reset asserted mid-burst or mid-lock aborts the operation with no write that cycle.
- FSM states: IDLE, LOCKED.
- IDLE arbitration (combinational, cycle t):
  - Winner w = first set bit of req, scanning from rr_ptr upward and wrapping N-1 -> 0.
  - At the edge closing t: q<=wdata[w], gnt<=onehot(w), owner<=w, rr_ptr<=(w+1) mod N.
  - If lock[w]=1, state<=LOCKED and busy<=1.
  - If req=0: gnt<=0 and q holds (Dff d = q). rr_ptr and owner hold.
- LOCKED (cycle t):
  - Only req[owner] is considered; other requesters are starved and gnt for them stays 0.
  - req[owner]=1: write wdata[owner], gnt<=onehot(owner).
  - lock[owner]=0 or req[owner]=0: release. Any write that cycle still occurs; state<=IDLE, busy<=0, rr_ptr<=(owner+1) mod N.
  - rr_ptr is frozen while locked.
- Write latency:
  - Data is visible on q one cycle after the request cycle.
  - gnt and the q update occur in the same cycle.
- Simultaneous req and lock from a non-winner: ignored that cycle; that requester must re-request.
- N=1 degenerates to pass-through with a lock; rr_ptr stays 0.

Optional Feature:
- Macro: DFF_SHARE_ARB_TIMEOUT_EN.
- Defined:
  - A counter increments each LOCKED cycle.
  - When LOCKED has lasted MAX_LOCK cycles, the next edge forces release: state<=IDLE, busy<=0, timeout_err pulses 1, rr_ptr<=(owner+1) mod N.
  - The owner's lock is then masked (treated as 0) until that requester deasserts lock for at least one cycle.
  - Its req remains eligible for ordinary unlocked grants.
- Undefined: locks are unbounded, there is no counter or mask, and timeout_err is constant 0.

Decomposition:
- Package dff_share_arb_pkg contains:
  - state enum {IDLE, LOCKED};
  - function onehot(idx, n);
  - constant/function for index width, $clog2(N) with a minimum of 1.
- Sub-module rr_pick (combinational rotate-priority picker): inputs req, rr_ptr; outputs valid and winner index.
- Storage is the existing Dff instantiated with WIDTH; this block drives its d.

Test Plan:
All scenarios use N=4, WIDTH=8.
1. Reset: reset=0 for 2 cycles while req=4'b1111 -> q=0x00, gnt=0, busy=0, owner=0. After release, first grant is 0001.
2. Single write: req=0010, wdata[1]=0xA5 in cycle t -> at t+1 gnt=0010, q=0xA5, owner=1. With req=0 at t+1 -> q stays 0xA5 and gnt=0 at t+2.
3. Round-robin fairness: req=1111, lock=0, held 5 cycles with wdata[i]=0x10+i -> gnt sequence 0001,0010,0100,1000,0001; q sequence 0x10,0x11,0x12,0x13,0x10.
4. Lock burst: with rr_ptr=2, req=1111 and lock=0100 for 3 cycles, then lock=0 -> gnt=0100 for 4 cycles and busy=1 during the lock. The next grant is 1000.
5. Reset mid-lock: reset=0 while busy=1 -> next cycle busy=0, gnt=0, q=0x00. Afterwards req=1111 grants 0001 first.
6. Timeout (macro defined, MAX_LOCK=4): req=0011, lock=0001 held 10 cycles -> gnt=0001 x4, a timeout_err pulse, then gnt alternates 0010/0001 unlocked with busy=0 while lock[0] stays high.
